prog_mem_ctrl: RTL and testbench

//  Writable program memory for the accumulator CPU, successor to the fixed instruction ROM.
//  It is a single-port RAM with a registered fetch port and a sequential loader port.
//  On reset it re-initialises itself to the boot image. A host (e.g. UART bootloader)
//  can then stream in a new program, which the CPU fetches via a req/valid handshake.

---
 rtl/prog_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_prog_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - writable program memory with boot-image init pass, fetch port and sequential loader
module prog_mem_ctrl #(
    parameter int ADDR_BUS       = 11,
    parameter int DATA_SIZE      = 16,
    parameter int OPCODE_BITS    = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Fetch_Req,
    input  logic [ADDR_BUS-1:0]  Fetch_Addr,
    output logic [DATA_SIZE-1:0] Fetch_Data,
    output logic                 Fetch_Valid,
    output logic                 Ready,
    input  logic                 Load_Start,
    input  logic                 Load_We,
    input  logic [DATA_SIZE-1:0] Load_Data,
    input  logic                 Load_Done,
    output logic [ADDR_BUS:0]    Load_Count,
    output logic                 Load_Ovf
);

    localparam int DEPTH     = 1 << ADDR_BUS;
    localparam int OPND_BITS = DATA_SIZE - OPCODE_BITS;
    localparam int IMG_LEN   = 7;
    localparam int INIT_LEN  = (CLEAR_ON_RESET != 0) ? DEPTH : IMG_LEN;
    localparam logic [ADDR_BUS:0] INIT_LAST = (ADDR_BUS+1)'(INIT_LEN - 1);

    localparam int OP_HLT  = 0;
    localparam int OP_STO  = 1;
    localparam int OP_LD   = 2;
    localparam int OP_LDI  = 3;
    localparam int OP_ADDI = 5;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    function automatic logic [DATA_SIZE-1:0] enc(input int op, input int opnd);
        logic [OPCODE_BITS-1:0] op_f;
        logic [OPND_BITS-1:0]   opnd_f;
        op_f   = OPCODE_BITS'(op);
        opnd_f = OPND_BITS'(opnd);
        return {op_f, opnd_f};
    endfunction

    // Words past the image come back as zero, which is what the clearing pass writes.
    function automatic logic [DATA_SIZE-1:0] boot_word(input int idx);
        case (idx)
            0:       return enc(OP_LDI, 16);
            1:       return enc(OP_STO, 1);
            2:       return enc(OP_LD, 1);
            3:       return enc(OP_ADDI, 255);
            4:       return enc(OP_STO, 2);
            5:       return enc(OP_LD, 16);
            6:       return enc(OP_HLT, 0);
            default: return '0;
        endcase
    endfunction

    logic [DATA_SIZE-1:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [ADDR_BUS:0]    ptr_q, ptr_d;
    logic [ADDR_BUS:0]    cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [DATA_SIZE-1:0] fdata_q, fdata_d;
    logic                 fvalid_q, fvalid_d;

    logic                 mem_we;
    logic [ADDR_BUS-1:0]  mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        fdata_d   = fdata_q;
        fvalid_d  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ptr_q[ADDR_BUS-1:0];
        mem_wdata = Load_Data;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_wdata = boot_word(int'(ptr_q));
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (Load_Start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (Fetch_Req) begin
                    fdata_d  = mem[Fetch_Addr];
                    fvalid_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (Load_Start) begin
                    ptr_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    // Pointer MSB set means the array is full; never wrap onto word 0.
                    if (Load_We) begin
                        if (!ptr_q[ADDR_BUS]) begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                            cnt_d  = cnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (Load_Done) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            fdata_q  <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            fdata_q  <= fdata_d;
            fvalid_q <= fvalid_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we && Reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign Fetch_Data  = fdata_q;
    assign Fetch_Valid = fvalid_q;
    assign Ready       = (state_q == ST_IDLE);
    assign Load_Count  = cnt_q;
    assign Load_Ovf    = ovf_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - scoreboard bench for prog_mem_ctrl with randomized stimulus and reference model
module tb_prog_mem_ctrl;

    localparam int DEPTH = 2048;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset = 1'b0;
    logic        Fetch_Req = 1'b0;
    logic [10:0] Fetch_Addr = '0;
    logic [15:0] Fetch_Data;
    logic        Fetch_Valid;
    logic        Ready;
    logic        Load_Start = 1'b0;
    logic        Load_We = 1'b0;
    logic [15:0] Load_Data = '0;
    logic        Load_Done = 1'b0;
    logic [11:0] Load_Count;
    logic        Load_Ovf;

    prog_mem_ctrl u_dut (
        .Clk(Clk), .Reset(Reset),
        .Fetch_Req(Fetch_Req), .Fetch_Addr(Fetch_Addr),
        .Fetch_Data(Fetch_Data), .Fetch_Valid(Fetch_Valid), .Ready(Ready),
        .Load_Start(Load_Start), .Load_We(Load_We), .Load_Data(Load_Data),
        .Load_Done(Load_Done), .Load_Count(Load_Count), .Load_Ovf(Load_Ovf)
    );

    logic        s_rst = 1'b0;
    logic        s_req = 1'b0;
    logic [2:0]  s_addr = '0;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_start = 1'b0;
    logic        s_we = 1'b0;
    logic [15:0] s_wdata = '0;
    logic        s_done = 1'b0;
    logic [3:0]  s_count;
    logic        s_ovf;

    prog_mem_ctrl #(.ADDR_BUS(3), .CLEAR_ON_RESET(0)) u_small (
        .Clk(Clk), .Reset(s_rst),
        .Fetch_Req(s_req), .Fetch_Addr(s_addr),
        .Fetch_Data(s_data), .Fetch_Valid(s_valid), .Ready(s_ready),
        .Load_Start(s_start), .Load_We(s_we), .Load_Data(s_wdata),
        .Load_Done(s_done), .Load_Count(s_count), .Load_Ovf(s_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: boot image written as the hand-encoded words.
    logic [15:0] boot_img [7] = '{16'h1810, 16'h0801, 16'h1001, 16'h28FF, 16'h0802, 16'h1010, 16'h0000};
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_q [$];
    bit          m_ready, m_loading, m_ovf, m_valid;
    int          m_init_left, m_lptr, m_cnt;
    logic [15:0] m_hold;
    bit          rst_req = 1'b0;
    bit          small_done = 1'b0;

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 7) ? boot_img[i] : 16'h0000;
        m_ready = 0; m_loading = 0; m_ovf = 0; m_valid = 0;
        m_init_left = DEPTH; m_lptr = 0; m_cnt = 0; m_hold = 16'h0000;
        exp_q.delete();
    endtask

    task automatic model_step();
        m_valid = 0;
        if (!Reset) begin
            reset_model();
        end else if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) m_ready = 1;
        end else if (m_ready) begin
            if (Load_Start) begin
                m_ready = 0; m_loading = 1; m_lptr = 0; m_cnt = 0; m_ovf = 0;
            end else if (Fetch_Req) begin
                m_valid = 1;
                m_hold  = ref_mem[int'(Fetch_Addr)];
                exp_q.push_back(m_hold);
            end
        end else if (m_loading) begin
            if (Load_Start) begin
                m_lptr = 0; m_cnt = 0; m_ovf = 0;
            end else begin
                if (Load_We) begin
                    if (m_lptr < DEPTH) begin
                        ref_mem[m_lptr] = Load_Data;
                        m_lptr++;
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (Load_Done) begin
                    m_loading = 0; m_ready = 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic rq, input logic [10:0] a, input logic st,
                       input logic we, input logic [15:0] d, input logic dn);
        @(negedge Clk);
        Reset = rst_req;
        Fetch_Req = rq; Fetch_Addr = a; Load_Start = st;
        Load_We = we; Load_Data = d; Load_Done = dn;
        model_step();
    endtask

    task automatic cyc_rand();
        logic [10:0] a;
        a = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 15)) : 11'($urandom);
        cyc($urandom_range(0, 9) < 6, a, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 19) == 0);
    endtask

    task automatic idle();
        cyc(1'b0, 11'd0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic fetch(input int a);
        cyc(1'b1, 11'(a), 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    always @(posedge Clk) begin
        #1;
        chk("ready", 32'(Ready), 32'(m_ready));
        chk("load_count", 32'(Load_Count), 32'(m_cnt));
        chk("load_ovf", 32'(Load_Ovf), 32'(m_ovf));
        chk("fetch_valid", 32'(Fetch_Valid), 32'(m_valid));
        if (Fetch_Valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch", 32'(Fetch_Valid), 32'd0);
            end else begin
                chk("fetch_data", 32'(Fetch_Data), 32'(exp_q.pop_front()));
            end
        end else begin
            chk("hold_data", 32'(Fetch_Data), 32'(m_hold));
        end
    end

    initial begin
        reset_model();
        repeat (3) cyc_rand();
        rst_req = 1'b1;
        repeat (2040) cyc_rand();
        repeat (10) idle();

        fetch(0); fetch(3); fetch(6); fetch(2047); idle();
        fetch(0); fetch(1); fetch(2); fetch(5); idle();

        cyc(1'b0, 11'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b1, 16'h5555, 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b1, 16'h1234, 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b0, 16'h0, 1'b1);
        fetch(1); fetch(4); idle();

        cyc(1'b1, 11'd3, 1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 11'd3, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        cyc(1'b1, 11'd3, 1'b0, 1'b1, 16'hCAFE, 1'b1);
        fetch(1); fetch(0); idle();

        repeat (1500) cyc_rand();
        repeat (3) idle();
        cyc(1'b0, 11'd0, 1'b0, 1'b0, 16'h0, 1'b1);

        cyc(1'b0, 11'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 11'd0, 1'b0, 1'b1, 16'($urandom), 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b0, 16'h0, 1'b1);
        fetch(0); fetch(2047); idle();

        cyc(1'b0, 11'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b1, 16'h1111, 1'b0);
        cyc(1'b0, 11'd0, 1'b0, 1'b1, 16'h2222, 1'b0);
        rst_req = 1'b0;
        repeat (3) idle();
        rst_req = 1'b1;
        repeat (DEPTH + 2) idle();
        fetch(0); fetch(1); idle(); idle();

        for (int i = 0; i < 2000 && !small_done; i++) @(negedge Clk);
        chk("small_done", 32'(small_done), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic s_drive(input logic rq, input logic [2:0] a, input logic st,
                           input logic we, input logic [15:0] d, input logic dn);
        @(negedge Clk);
        s_req = rq; s_addr = a; s_start = st; s_we = we; s_wdata = d; s_done = dn;
    endtask

    initial begin
        int n;
        repeat (3) s_drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge Clk);
        s_rst = 1'b1;
        chk("s_ready_at_release", 32'(s_ready), 32'd0);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!s_ready && n < 20);
        chk("s_init_cycles", 32'(n), 32'd7);

        s_drive(1'b1, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        s_drive(1'b1, 3'd5, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s_fetch0", 32'(s_data), 32'h1810);
        s_drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s_fetch5_valid", 32'(s_valid), 32'd1);
        chk("s_fetch5", 32'(s_data), 32'h1010);

        s_drive(1'b0, 3'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 9; i++) s_drive(1'b0, 3'd0, 1'b0, 1'b1, 16'(i), 1'b0);
        s_drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1);
        s_drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s_count", 32'(s_count), 32'd8);
        chk("s_ovf", 32'(s_ovf), 32'd1);
        chk("s_ready_after_load", 32'(s_ready), 32'd1);

        s_drive(1'b1, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        s_drive(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s_mem0", 32'(s_data), 32'd1);
        s_drive(1'b1, 3'd3, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s_mem7", 32'(s_data), 32'd8);
        s_drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("s_mem3", 32'(s_data), 32'd4);
        small_done = 1'b1;
    end

endmodule
